// File: rtl/pc_pkg.sv
// Shared fetch-PC definitions: PC source encodings and default memory-map constants
// (also used by CP0 and the instruction-memory model).
package pc_pkg;

  typedef logic [1:0] pc_src_t;

  localparam pc_src_t PC_SRC_SEQ   = 2'd0;
  localparam pc_src_t PC_SRC_REDIR = 2'd1;
  localparam pc_src_t PC_SRC_EXC   = 2'd2;
  localparam pc_src_t PC_SRC_ERET  = 2'd3;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_SIZE  = 32'h0000_4000;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: control requests from D/CP0 in, fetch PC and RAS prediction out.
interface pc_gen_if #(
  parameter int PC_W = 32
);
  logic            en;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            exc_req;
  logic            eret_req;
  logic [PC_W-1:0] epc;
  logic            ras_push;
  logic [PC_W-1:0] ras_push_addr;
  logic            ras_pop;
  logic [PC_W-1:0] pc;
  logic            pc_fault;
  logic [PC_W-1:0] ras_top;
  logic            ras_valid;
  logic [1:0]      pc_src;

  modport master (
    output en, redirect_valid, redirect_target, exc_req, eret_req, epc,
           ras_push, ras_push_addr, ras_pop,
    input  pc, pc_fault, ras_top, ras_valid, pc_src
  );

  modport slave (
    input  en, redirect_valid, redirect_target, exc_req, eret_req, epc,
           ras_push, ras_push_addr, ras_pop,
    output pc, pc_fault, ras_top, ras_valid, pc_src
  );
endinterface

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with wrapping top pointer and saturating count.
// push/pop arrive already qualified by the caller (stall/flush masked).
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_addr,
  output logic [W-1:0] top_data,
  output logic         valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] top, top_nxt, wr_idx;
  logic [CW-1:0] count, count_nxt;
  logic          wr_en;
  logic          empty;

  assign empty = (count == '0);

  always_comb begin
    top_nxt   = top;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_idx    = top;
    if (push && (!pop || empty)) begin
      // when full the new entry lands on the oldest slot, which is simply lost
      top_nxt = top + 1'b1;
      wr_idx  = top + 1'b1;
      wr_en   = 1'b1;
      if (count != CW'(DEPTH)) count_nxt = count + 1'b1;
    end else if (push && pop) begin
      wr_en = 1'b1;
    end else if (pop && !empty) begin
      top_nxt   = top - 1'b1;
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
    end else begin
      top   <= top_nxt;
      count <= count_nxt;
    end
  end

  // entries are deliberately not reset; count gates their visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_addr;
  end

  assign valid    = !empty;
  assign top_data = empty ? '0 : mem[top];
endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: prioritised next-PC mux, PC register, fetch-fault check and RAS.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(DEF_EXC_VECTOR),
  parameter int unsigned     INST_BYTES = 4,
  parameter logic [PC_W-1:0] IMEM_BASE  = PC_W'(DEF_IMEM_BASE),
  parameter logic [PC_W-1:0] IMEM_SIZE  = PC_W'(DEF_IMEM_SIZE),
  parameter int              RAS_DEPTH  = 8
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);
  // one extra bit so base + size never wraps
  localparam logic [PC_W:0] IM_LO = {1'b0, IMEM_BASE};
  localparam logic [PC_W:0] IM_HI = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  logic [PC_W-1:0] pc_q, pc_nxt;
  pc_src_t         src_q, src_nxt;
  logic            ras_ok;

  always_comb begin
    pc_nxt  = pc_q;
    src_nxt = src_q;
    if (bus.exc_req) begin
      pc_nxt  = EXC_VECTOR;
      src_nxt = PC_SRC_EXC;
    end else if (bus.eret_req) begin
      pc_nxt  = bus.epc;
      src_nxt = PC_SRC_ERET;
    end else if (bus.en && bus.redirect_valid) begin
      pc_nxt  = bus.redirect_target;
      src_nxt = PC_SRC_REDIR;
    end else if (bus.en) begin
      pc_nxt  = pc_q + PC_W'(INST_BYTES);
      src_nxt = PC_SRC_SEQ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      src_q <= PC_SRC_SEQ;
    end else begin
      pc_q  <= pc_nxt;
      src_q <= src_nxt;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_src   = src_q;
  assign bus.pc_fault = (pc_q[1:0] != 2'b00) ||
                        ({1'b0, pc_q} < IM_LO) ||
                        ({1'b0, pc_q} >= IM_HI);

  // a flushed or stalled instruction must leave the RAS untouched
  assign ras_ok = bus.en && !bus.exc_req && !bus.eret_req;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_ok && bus.ras_push),
    .pop       (ras_ok && bus.ras_pop),
    .push_addr (bus.ras_push_addr),
    .top_data  (bus.ras_top),
    .valid     (bus.ras_valid)
  );
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: PC sequencing/priority, fault window and RAS behaviour.
module tb_pc_gen;
  import pc_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pc_gen_if #(.PC_W(32)) bus ();

  pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic [1:0] exp_src,
                        input logic exp_fault);
    check({tag, ".pc"}, bus.pc, exp_pc);
    check({tag, ".src"}, 32'(bus.pc_src), 32'(exp_src));
    check({tag, ".fault"}, 32'(bus.pc_fault), 32'(exp_fault));
  endtask

  task automatic chk_ras(input string tag, input logic [31:0] exp_top, input logic exp_valid);
    check({tag, ".ras_top"}, bus.ras_top, exp_top);
    check({tag, ".ras_valid"}, 32'(bus.ras_valid), 32'(exp_valid));
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    bus.exc_req = 1'b0;
    bus.eret_req = 1'b0;
    bus.epc = '0;
    bus.ras_push = 1'b0;
    bus.ras_push_addr = '0;
    bus.ras_pop = 1'b0;

    #2;
    chk_pc("reset", 32'h3000, PC_SRC_SEQ, 1'b0);
    chk_ras("reset", 32'h0, 1'b0);
    #1 reset = 1'b0;

    // sequential fetch
    bus.en = 1'b1;
    tick(); chk_pc("seq1", 32'h3004, PC_SRC_SEQ, 1'b0);
    tick(); chk_pc("seq2", 32'h3008, PC_SRC_SEQ, 1'b0);
    tick(); chk_pc("seq3", 32'h300C, PC_SRC_SEQ, 1'b0);

    // stalled redirect holds, then takes effect
    bus.en = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h3100;
    tick(); chk_pc("stall", 32'h300C, PC_SRC_SEQ, 1'b0);
    bus.en = 1'b1;
    tick(); chk_pc("redir", 32'h3100, PC_SRC_REDIR, 1'b0);
    bus.redirect_valid = 1'b0;

    // exc beats eret, both ignore en
    bus.en = 1'b0;
    bus.exc_req = 1'b1;
    bus.eret_req = 1'b1;
    bus.epc = 32'h3050;
    tick(); chk_pc("exc", 32'h4180, PC_SRC_EXC, 1'b0);
    bus.exc_req = 1'b0;
    tick(); chk_pc("eret", 32'h3050, PC_SRC_ERET, 1'b0);
    bus.eret_req = 1'b0;

    // fault window boundaries
    bus.en = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h3002;
    tick(); chk_pc("misalign", 32'h3002, PC_SRC_REDIR, 1'b1);
    bus.redirect_target = 32'h7000;
    tick(); chk_pc("above", 32'h7000, PC_SRC_REDIR, 1'b1);
    bus.redirect_target = 32'h6FFC;
    tick(); chk_pc("lastok", 32'h6FFC, PC_SRC_REDIR, 1'b0);
    bus.redirect_valid = 1'b0;
    tick(); chk_pc("seq_out", 32'h7000, PC_SRC_SEQ, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h2FFC;
    tick(); chk_pc("below", 32'h2FFC, PC_SRC_REDIR, 1'b1);
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick(); chk_pc("wrap", 32'h0000_0000, PC_SRC_SEQ, 1'b1);

    // RAS: overfill, then drain
    bus.ras_push = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.ras_push_addr = 32'h3008 + 32'(8 * k);
      tick();
      chk_ras($sformatf("push%0d", k), 32'h3008 + 32'(8 * k), 1'b1);
    end
    bus.ras_push = 1'b0;
    bus.ras_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_ras($sformatf("prepop%0d", i), 32'h3048 - 32'(8 * i), 1'b1);
      tick();
    end
    chk_ras("drained", 32'h0, 1'b0);
    tick(); chk_ras("underflow", 32'h0, 1'b0);
    bus.ras_pop = 1'b0;

    // push+pop on an empty stack behaves as a push
    bus.ras_push = 1'b1;
    bus.ras_pop = 1'b1;
    bus.ras_push_addr = 32'h3600;
    tick(); chk_ras("pp_empty", 32'h3600, 1'b1);
    bus.ras_push = 1'b0;
    tick(); chk_ras("pp_empty_pop", 32'h0, 1'b0);
    bus.ras_pop = 1'b0;

    // push+pop on non-empty replaces top, count unchanged
    bus.ras_push = 1'b1;
    bus.ras_push_addr = 32'h3018;
    tick();
    bus.ras_push_addr = 32'h3020;
    tick(); chk_ras("top3020", 32'h3020, 1'b1);
    bus.ras_pop = 1'b1;
    bus.ras_push_addr = 32'h3500;
    tick(); chk_ras("pp_replace", 32'h3500, 1'b1);
    bus.ras_push = 1'b0;
    tick(); chk_ras("pp_count", 32'h3018, 1'b1);
    bus.ras_pop = 1'b0;

    // flushed or stalled push leaves the RAS alone
    bus.ras_push = 1'b1;
    bus.ras_push_addr = 32'h3999;
    bus.exc_req = 1'b1;
    tick(); chk_ras("push_exc", 32'h3018, 1'b1);
    check("push_exc.pc", bus.pc, 32'h4180);
    bus.exc_req = 1'b0;
    bus.en = 1'b0;
    tick(); chk_ras("push_stall", 32'h3018, 1'b1);
    bus.ras_push = 1'b0;
    bus.en = 1'b1;
    bus.ras_pop = 1'b1;
    tick(); chk_ras("last_pop", 32'h0, 1'b0);
    bus.ras_pop = 1'b0;

    // async reset between edges
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h3100;
    bus.ras_push = 1'b1;
    bus.ras_push_addr = 32'h3700;
    tick(); chk_pc("pre_rst", 32'h3100, PC_SRC_REDIR, 1'b0);
    chk_ras("pre_rst", 32'h3700, 1'b1);
    bus.redirect_valid = 1'b0;
    bus.ras_push = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk_pc("async_rst", 32'h3000, PC_SRC_SEQ, 1'b0);
    chk_ras("async_rst", 32'h0, 1'b0);
    #2 reset = 1'b0;
    tick(); chk_pc("post_rst", 32'h3004, PC_SRC_SEQ, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
